// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
//
// Central stall/flush controller for a 5-stage MIPS pipeline. It drives the
// enables and synchronous clears of the PC register and the four pipeline
// registers (IF/ID, ID/EX, EX/MEM, MEM/WB). It also sequences the multi-cycle
// divide stall and keeps a free-running count of front-end stall cycles.
//
// Simultaneous events in RUN are resolved by fixed priority:
//   exc_valid > dmem_stall > div_start > load_use > imem_stall
//
// All control outputs are combinational in (state, cnt, inputs). That gives
// every event a same-cycle response. Only state, cnt and stall_cnt are
// registered.
//
// Ports
//   clk          clock, rising edge
//   rst          synchronous active-high reset; forces every control output low
//   load_use     ID instruction depends on the load currently in EX
//   imem_stall   instruction fetch not complete this cycle
//   dmem_stall   MEM-stage data access not complete this cycle
//   div_start    DIV/DIVU in EX (held until it leaves EX)
//   exc_valid    MEM-stage instruction raises an exception
//   pc_en, *_en  register load enables
//   *_clr        bubble insert (dominates en inside the flop)
//   exc_redirect select exception vector as next PC
//   div_busy     high while waiting on the divider
//   div_done     pulse on the cycle the divide result is released
//   div_abort    pulse when an exception kills an in-flight divide
//   stall_cnt    cycles with pc_en=0 (wraps)
//
// state    | meaning
// ---------+-------------------------------------------------------------
// RUN      | normal flow, hazard/priority resolution
// DIV_WAIT | divide in EX, front end held, cnt counts down to release
// FLUSH    | single cycle after an exception redirect, kills stale fetch

module pipe_hazard_ctrl #(
  parameter int unsigned DIV_CYCLES = 32,
  parameter int unsigned CNT_W      = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_use,
  input  logic        imem_stall,
  input  logic        dmem_stall,
  input  logic        div_start,
  input  logic        exc_valid,
  output logic        pc_en,
  output logic        if_id_en,
  output logic        id_ex_en,
  output logic        ex_mem_en,
  output logic        mem_wb_en,
  output logic        if_id_clr,
  output logic        id_ex_clr,
  output logic        ex_mem_clr,
  output logic        mem_wb_clr,
  output logic        exc_redirect,
  output logic        div_busy,
  output logic        div_done,
  output logic        div_abort,
  output logic [31:0] stall_cnt
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    DIV_WAIT = 2'd1,
    FLUSH    = 2'd2
  } state_t;

  // The issue cycle and the done cycle are both outside the countdown.
  // So the countdown covers DIV_CYCLES-2 cycles.
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DIV_CYCLES - 2);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [31:0]      stall_cnt_q;

  always_comb begin
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    id_ex_en     = 1'b1;
    ex_mem_en    = 1'b1;
    mem_wb_en    = 1'b1;
    if_id_clr    = 1'b0;
    id_ex_clr    = 1'b0;
    ex_mem_clr   = 1'b0;
    mem_wb_clr   = 1'b0;
    exc_redirect = 1'b0;
    div_busy     = 1'b0;
    div_done     = 1'b0;
    div_abort    = 1'b0;
    state_nxt    = state;
    cnt_nxt      = cnt;

    if (rst) begin
      pc_en     = 1'b0;
      if_id_en  = 1'b0;
      id_ex_en  = 1'b0;
      ex_mem_en = 1'b0;
      mem_wb_en = 1'b0;
      state_nxt = RUN;
      cnt_nxt   = CNT_ZERO;
    end else begin
      unique case (state)
        RUN: begin
          if (exc_valid) begin
            exc_redirect = 1'b1;
            if_id_clr    = 1'b1;
            id_ex_clr    = 1'b1;
            ex_mem_clr   = 1'b1;
            mem_wb_clr   = 1'b1;
            state_nxt    = FLUSH;
          end else if (dmem_stall) begin
            // Freeze everything up to MEM. Bubble into WB. A waiting divide is
            // held off until the data access completes.
            pc_en      = 1'b0;
            if_id_en   = 1'b0;
            id_ex_en   = 1'b0;
            ex_mem_en  = 1'b0;
            mem_wb_clr = 1'b1;
          end else if (div_start) begin
            pc_en      = 1'b0;
            if_id_en   = 1'b0;
            id_ex_en   = 1'b0;
            ex_mem_clr = 1'b1;
            cnt_nxt    = CNT_LOAD;
            state_nxt  = DIV_WAIT;
          end else if (load_use) begin
            pc_en     = 1'b0;
            if_id_en  = 1'b0;
            id_ex_clr = 1'b1;
          end else if (imem_stall) begin
            pc_en     = 1'b0;
            if_id_clr = 1'b1;
          end
        end

        DIV_WAIT: begin
          div_busy = 1'b1;
          if (exc_valid) begin
            // Same response as in RUN. The divide is abandoned.
            exc_redirect = 1'b1;
            if_id_clr    = 1'b1;
            id_ex_clr    = 1'b1;
            ex_mem_clr   = 1'b1;
            mem_wb_clr   = 1'b1;
            div_abort    = 1'b1;
            cnt_nxt      = CNT_ZERO;
            state_nxt    = FLUSH;
          end else begin
            pc_en    = 1'b0;
            if_id_en = 1'b0;
            id_ex_en = 1'b0;
            if (cnt != CNT_ZERO) begin
              // The divider keeps counting through a data stall.
              ex_mem_clr = 1'b1;
              cnt_nxt    = cnt - CNT_ONE;
              if (dmem_stall) begin
                ex_mem_en  = 1'b0;
                mem_wb_clr = 1'b1;
              end
            end else if (dmem_stall) begin
              // Result ready but MEM is busy. Hold it in EX.
              ex_mem_en  = 1'b0;
              mem_wb_clr = 1'b1;
            end else begin
              // div_start is still high here. It refers to the divide now
              // leaving EX, so it must not retrigger.
              div_done  = 1'b1;
              state_nxt = RUN;
            end
          end
        end

        FLUSH: begin
          // The MEM stage holds a bubble, so exc_valid cannot be genuine here.
          if_id_clr = 1'b1;
          state_nxt = RUN;
        end

        default: begin
          state_nxt = RUN;
          cnt_nxt   = CNT_ZERO;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      cnt   <= CNT_ZERO;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= 32'd0;
    end else if (!pc_en) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Testbench for pipe_hazard_ctrl (DIV_CYCLES=4).
// The driver applies one input vector per cycle. A reference model computes
// the expected outputs from the priority/divide rules and pushes them into a
// queue. A monitor pops the queue on each falling edge and compares.
// The model tracks a divide as "cycles remaining", not as a state encoding.

module tb_pipe_hazard_ctrl;

  localparam int DIVC = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        load_use = 1'b0;
  logic        imem_stall = 1'b0;
  logic        dmem_stall = 1'b0;
  logic        div_start = 1'b0;
  logic        exc_valid = 1'b0;
  logic        pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic        if_id_clr, id_ex_clr, ex_mem_clr, mem_wb_clr;
  logic        exc_redirect, div_busy, div_done, div_abort;
  logic [31:0] stall_cnt;

  pipe_hazard_ctrl #(.DIV_CYCLES(DIVC), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .load_use(load_use), .imem_stall(imem_stall), .dmem_stall(dmem_stall),
    .div_start(div_start), .exc_valid(exc_valid),
    .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en),
    .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en),
    .if_id_clr(if_id_clr), .id_ex_clr(id_ex_clr),
    .ex_mem_clr(ex_mem_clr), .mem_wb_clr(mem_wb_clr),
    .exc_redirect(exc_redirect), .div_busy(div_busy),
    .div_done(div_done), .div_abort(div_abort),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    int          cyc;
    logic [12:0] ctl;
    logic [31:0] cnt;
    logic        cnt_known;
  } exp_t;

  exp_t exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // reference model state
  int          m_div_left  = 0;   // remaining DIV_WAIT cycles, incl. done cycle
  bit          m_flush     = 0;
  logic [31:0] m_stall     = 32'd0;
  bit          m_cnt_known = 0;

  task automatic model_step(input bit r, lu, im, dm, ds, ex,
                            output logic [12:0] ctl);
    bit pc = 1, ifid = 1, idex = 1, exmem = 1, memwb = 1;
    bit c_ifid = 0, c_idex = 0, c_exmem = 0, c_memwb = 0;
    bit redir = 0, busy = 0, done = 0, abort = 0;
    if (r) begin
      pc = 0; ifid = 0; idex = 0; exmem = 0; memwb = 0;
      m_div_left = 0;
      m_flush    = 0;
    end else if (m_flush) begin
      c_ifid  = 1;
      m_flush = 0;
    end else if (m_div_left > 0) begin
      busy = 1;
      if (ex) begin
        redir = 1; abort = 1;
        c_ifid = 1; c_idex = 1; c_exmem = 1; c_memwb = 1;
        m_div_left = 0;
        m_flush    = 1;
      end else begin
        pc = 0; ifid = 0; idex = 0;
        if (m_div_left == 1) begin
          if (dm) begin
            exmem = 0; c_memwb = 1;
          end else begin
            done = 1;
            m_div_left = 0;
          end
        end else begin
          c_exmem = 1;
          if (dm) begin
            exmem = 0; c_memwb = 1;
          end
          m_div_left--;
        end
      end
    end else if (ex) begin
      redir = 1;
      c_ifid = 1; c_idex = 1; c_exmem = 1; c_memwb = 1;
      m_flush = 1;
    end else if (dm) begin
      pc = 0; ifid = 0; idex = 0; exmem = 0; c_memwb = 1;
    end else if (ds) begin
      pc = 0; ifid = 0; idex = 0; c_exmem = 1;
      m_div_left = DIVC - 1;
    end else if (lu) begin
      pc = 0; ifid = 0; c_idex = 1;
    end else if (im) begin
      pc = 0; c_ifid = 1;
    end
    ctl = {pc, ifid, idex, exmem, memwb, c_ifid, c_idex, c_exmem, c_memwb,
           redir, busy, done, abort};
    if (r) begin
      m_stall     = 32'd0;
      m_cnt_known = 1;
    end else if (!pc) begin
      m_stall = m_stall + 32'd1;
    end
  endtask

  task automatic step(input bit r, lu, im, dm, ds, ex);
    exp_t e;
    logic [12:0] ctl;
    @(posedge clk);
    #1;
    rst = r; load_use = lu; imem_stall = im;
    dmem_stall = dm; div_start = ds; exc_valid = ex;
    e.cyc       = cyc;
    e.cnt       = m_stall;
    e.cnt_known = m_cnt_known;
    model_step(r, lu, im, dm, ds, ex, ctl);
    e.ctl = ctl;
    exp_q.push_back(e);
    cyc++;
  endtask

  // monitor
  initial begin
    exp_t e;
    logic [12:0] act;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        act = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
               if_id_clr, id_ex_clr, ex_mem_clr, mem_wb_clr,
               exc_redirect, div_busy, div_done, div_abort};
        n_checks++;
        if (act !== e.ctl) begin
          n_fail++;
          $display("FAIL ctl cyc=%0d actual=%b expected=%b", e.cyc, act, e.ctl);
        end
        if (e.cnt_known) begin
          n_checks++;
          if (stall_cnt !== e.cnt) begin
            n_fail++;
            $display("FAIL stall_cnt cyc=%0d actual=%0d expected=%0d",
                     e.cyc, stall_cnt, e.cnt);
          end
        end
      end
    end
  end

  initial begin
    int guard;
    // reset, then idle
    step(1,0,0,0,0,0); step(1,0,0,0,0,0);
    step(0,0,0,0,0,0); step(0,0,0,0,0,0);
    // load-use pulse
    step(0,1,0,0,0,0); step(0,0,0,0,0,0);
    // plain divide: issue + 3 wait cycles
    repeat (4) step(0,0,0,0,1,0);
    step(0,0,0,0,0,0);
    // divide with dmem_stall on the done cycle for 2 cycles
    repeat (3) step(0,0,0,0,1,0);
    repeat (2) step(0,0,0,1,1,0);
    step(0,0,0,0,1,0);
    step(0,0,0,0,0,0);
    // dmem_stall during countdown
    step(0,0,0,0,1,0); step(0,0,0,1,1,0); step(0,0,0,1,1,0); step(0,0,0,0,1,0);
    step(0,0,0,0,0,0);
    // exception on DIV_WAIT cycle 2, then FLUSH, then RUN
    step(0,0,0,0,1,0); step(0,0,0,0,1,0); step(0,0,0,0,1,1);
    step(0,0,0,0,0,1); step(0,0,0,0,0,0);
    // plain exception, imem_stall alone
    step(0,0,0,0,0,1); step(0,0,0,0,0,0); step(0,0,1,0,0,0); step(0,0,0,0,0,0);
    // simultaneous events
    step(0,1,1,0,0,0);
    step(0,0,0,1,1,0); step(0,0,0,1,1,0);
    repeat (4) step(0,0,0,0,1,0);
    step(0,0,0,0,0,0);
    // reset mid-divide
    step(0,0,0,0,1,0); step(0,0,0,0,1,0); step(1,0,0,0,1,0); step(0,0,0,0,0,0);
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0,99) == 0,
           $urandom_range(0,4) == 0,
           $urandom_range(0,3) == 0,
           $urandom_range(0,4) == 0,
           $urandom_range(0,5) == 0,
           $urandom_range(0,15) == 0);
    end
    step(0,0,0,0,0,0);
    guard = 0;
    while (exp_q.size() != 0 && guard < 10) begin
      @(posedge clk);
      guard++;
    end
    @(posedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain actual=%0d pending expected=0 pending", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Central stall/flush controller for the 5-stage MIPS pipeline. Drives the enable and clear inputs of the PC register and the four `FlopEnRC` pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB) from hazard, memory-wait, multi-cycle divide and exception events. It resolves simultaneous events by fixed priority, sequences the multi-cycle divide stall, and counts stall cycles for performance monitoring.

## Interface
- `DIV_CYCLES`, 32: EX-stage cycles a divide occupies, including the issue cycle; legal range is 2..256.
- `CNT_W`, 8: width of the divide countdown; must satisfy 2^CNT_W ≥ DIV_CYCLES.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `load_use`  in  1  the ID instruction needs the result of the load in EX.
- `imem_stall`  in  1  instruction fetch is not complete this cycle.
- `dmem_stall`  in  1  the MEM-stage data access is not complete this cycle.
- `div_start`  in  1  a DIV/DIVU instruction is in EX; held until it leaves EX.
- `exc_valid`  in  1  the MEM-stage instruction raises an exception.
- `pc_en`  out  1  PC register load enable.
- `if_id_en`, `id_ex_en`, `ex_mem_en`, `mem_wb_en`  out  1 each  pipeline register enables.
- `if_id_clr`, `id_ex_clr`, `ex_mem_clr`, `mem_wb_clr`  out  1 each  synchronous bubble insert; takes priority over en inside the flop.
- `exc_redirect`  out  1  selects the exception vector as the next PC.
- `div_busy`  out  1  high while in DIV_WAIT.
- `div_done`  out  1  one-cycle pulse on the final divide cycle.
- `div_abort`  out  1  one-cycle pulse when an exception kills an in-flight divide.
- `stall_cnt`  out  32  count of cycles with pc_en=0; wraps at 2^32.

## Operation
- States are RUN, DIV_WAIT and FLUSH, plus a countdown `cnt[CNT_W-1:0]`. All control outputs are combinational functions of the state, `cnt` and the inputs.
- During reset (`rst`=1): all en outputs and all clr outputs are 0, `exc_redirect`, `div_busy`, `div_done` and `div_abort` are 0, and all other inputs are ignored. On the next edge the state becomes RUN, `cnt`=0 and `stall_cnt`=0.
- Default (RUN with no events): every en is 1 and every clr is 0.
- In RUN, the fixed priority is exc_valid > dmem_stall > div_start > load_use > imem_stall:
  - **exc_valid:** `pc_en`=1 and `exc_redirect`=1. `if_id_clr`, `id_ex_clr`, `ex_mem_clr` and `mem_wb_clr` are all 1. Next state is FLUSH.
  - **dmem_stall:** `pc_en`, `if_id_en`, `id_ex_en` and `ex_mem_en` are 0; `mem_wb_clr`=1. The state is unchanged. A pending `div_start` is not accepted.
  - **div_start:** `pc_en`, `if_id_en` and `id_ex_en` are 0; `ex_mem_clr`=1. `cnt` loads DIV_CYCLES-2. Next state is DIV_WAIT.
  - **load_use** (with or without imem_stall): `pc_en`=0 and `if_id_en`=0; `id_ex_clr`=1.
  - **imem_stall alone:** `pc_en`=0; `if_id_clr`=1; the other registers advance.
- **DIV_WAIT:**
  - `div_busy`=1. `pc_en`, `if_id_en` and `id_ex_en` are 0.
  - While `cnt`≠0: `ex_mem_clr`=1 and `cnt` decrements each cycle. `dmem_stall` does not stop the countdown; it additionally forces `ex_mem_en`=0 and `mem_wb_clr`=1.
  - When `cnt`=0: `div_done`=1 and the result is released with `ex_mem_en`=1 and `ex_mem_clr`=0. Next state is RUN. `div_start` is still high this cycle and must be ignored.
  - If `dmem_stall`=1 when `cnt`=0: stay in DIV_WAIT with `cnt` held at 0. `div_done` pulses only on the cycle that exits.
  - `exc_valid` in any DIV_WAIT cycle: apply the RUN exception response, assert `div_abort`=1, and go to FLUSH.
- **FLUSH** (one cycle): `if_id_clr`=1 to kill the in-flight fetch; all en are 1. Next state is RUN. `exc_valid` in FLUSH is ignored, because the MEM stage holds a bubble.
- `stall_cnt` increments on every non-reset cycle in which `pc_en`=0.

## Timing
- Every event gets its response in the same cycle (zero latency). Register effects appear on the next edge.
- A divide holds the front end for exactly DIV_CYCLES cycles when there is no dmem_stall: the issue cycle, DIV_CYCLES-2 countdown cycles, and the done cycle.
- An exception costs 2 cycles: the redirect cycle plus FLUSH.
- `rst` asserted mid-divide: the state returns to RUN with no `div_done` or `div_abort` pulse.

## Test plan
- **Reset:** `rst`=1 for 2 cycles → all en and clr are 0 and `stall_cnt`=0. After release with no events, all en are 1.
- **Load-use:** `load_use` pulsed for 1 cycle → `pc_en`=0, `if_id_en`=0, `id_ex_clr`=1 that cycle, and `stall_cnt` becomes 1.
- **Divide, DIV_CYCLES=4:** `div_start` held → `div_busy` is high for 3 cycles, `div_done` pulses on the 3rd, and `stall_cnt`=4.
- **Divide with dmem_stall:** `dmem_stall` asserted on the done cycle for 2 cycles → the state stays in DIV_WAIT, `cnt` stays 0, and `div_done` pulses only on the exit cycle.
- **Exception during divide:** `exc_valid` on DIV_WAIT cycle 2 → `div_abort`=1, `exc_redirect`=1 and all four clr are 1. The next cycle is FLUSH with only `if_id_clr`=1, then RUN.
- **Simultaneous events:** `load_use`+`imem_stall` → load_use response. `dmem_stall`+`div_start` → dmem response, and the divide starts on the first cycle after `dmem_stall` drops.
